// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller: register offsets,
// source count and the priority encoder used to build the ID register.
package irq_ctrl_pkg;

    localparam int NSRC = 6;

    localparam logic [1:0] IRQ_PEND = 2'd0;
    localparam logic [1:0] IRQ_MASK = 2'd1;
    localparam logic [1:0] IRQ_MODE = 2'd2;
    localparam logic [1:0] IRQ_ID   = 2'd3;

    localparam int ID_VALID_BIT = 31;

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic logic [2:0] priorityIndex(input logic [NSRC-1:0] vec);
        priorityIndex = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                priorityIndex = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with a one-cycle history flop, giving the
// synchronised level and a single-cycle rising-edge strobe.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   prev;

    // prev follows s in every mode so a later switch to edge mode sees no false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncChain <= '0;
            prev      <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], src};
            prev      <= s;
        end
    end

    assign s    = syncChain[SYNC_STAGES-1];
    assign rise = s & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding HWInt[7:2]: synchronises sources, latches them
// as edge/level pending bits, masks them and exposes a small bus register file.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NSRC-1:0] hwint
);

    logic [NSRC-1:0] syncLevel;
    logic [NSRC-1:0] syncRise;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] pendNext;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] wBits;
    logic [NSRC-1:0] pendClear;
    logic [NSRC-1:0] modeChange;
    logic [31:0]     idValue;
    logic            writeEn;
    logic            unusedWdata;

    for (genvar i = 0; i < NSRC; i++) begin : gSync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) uSync (
            .clk  (clk),
            .reset(reset),
            .src  (irq_src[i]),
            .s    (syncLevel[i]),
            .rise (syncRise[i])
        );
    end

    assign writeEn     = sel & we;
    assign wBits       = wdata[NSRC-1:0];
    assign unusedWdata = ^wdata[31:NSRC];
    assign pendClear   = (writeEn && addr == IRQ_PEND) ? wBits : '0;
    assign modeChange  = (writeEn && addr == IRQ_MODE) ? (wBits ^ mode) : '0;

    // Edge bits: a new edge beats a simultaneous W1C. Level bits track s.
    // A mode change on a bit drops whatever it had pending.
    assign pendNext = ~modeChange &
                      ((mode & (syncRise | (pend & ~pendClear))) | (~mode & syncLevel));

    assign active = pend & mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend  <= '0;
            mask  <= '0;
            mode  <= '0;
            hwint <= '0;
        end else begin
            pend  <= pendNext;
            hwint <= active;
            if (writeEn && addr == IRQ_MASK) begin
                mask <= wBits;
            end
            if (writeEn && addr == IRQ_MODE) begin
                mode <= wBits;
            end
        end
    end

    always_comb begin
        idValue               = '0;
        idValue[ID_VALID_BIT] = |active;
        idValue[2:0]          = priorityIndex(active);
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                IRQ_PEND: rdata = {{(32-NSRC){1'b0}}, pend};
                IRQ_MASK: rdata = {{(32-NSRC){1'b0}}, mask};
                IRQ_MODE: rdata = {{(32-NSRC){1'b0}}, mode};
                default:  rdata = idValue;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued as stimulus is
// applied and popped against register reads and the hwint output.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic            sel = 1'b0;
    logic            we = 1'b0;
    logic [1:0]      addr = 2'd0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic [NSRC-1:0] hwint;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expT;

    expT expQ[$];
    int  checkCount = 0;
    int  passCount  = 0;

    irq_ctrl #(
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_src(irq_src),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .hwint  (hwint)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] value);
        expQ.push_back('{tag, value});
    endtask

    task automatic popCompare(input logic [31:0] observed);
        expT front;
        if (expQ.size() == 0) begin
            checkOutput("scoreboardDepth", 32'(expQ.size()), 32'd1);
        end else begin
            front = expQ.pop_front();
            checkOutput(front.tag, observed, front.value);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NSRC-1:0] src);
        irq_src = src;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic readExpect(input string tag, input logic [1:0] a, input logic [31:0] exp);
        pushExpect(tag, exp);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        popCompare(rdata);
        sel  = 1'b0;
    endtask

    task automatic hwintExpect(input string tag, input logic [NSRC-1:0] exp);
        pushExpect(tag, {{(32-NSRC){1'b0}}, exp});
        popCompare({{(32-NSRC){1'b0}}, hwint});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not finish, checks so far %0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12 reset = 1'b1;
        tick(1);

        // Reset state
        readExpect("rstPend", IRQ_PEND, 32'h0);
        readExpect("rstMask", IRQ_MASK, 32'h0);
        readExpect("rstMode", IRQ_MODE, 32'h0);
        readExpect("rstId",   IRQ_ID,   32'h0);
        hwintExpect("rstHwint", 6'h00);

        // Edge mode with acknowledge
        busWrite(IRQ_MODE, 32'h3F);
        busWrite(IRQ_MASK, 32'h04);
        readExpect("modeAll", IRQ_MODE, 32'h3F);
        readExpect("maskSrc2", IRQ_MASK, 32'h04);
        applyStimulus(6'h04);
        tick(2);
        readExpect("edgeNotYet", IRQ_PEND, 32'h0);
        tick(1);
        readExpect("edgePend", IRQ_PEND, 32'h04);
        hwintExpect("edgeHwintLag", 6'h00);
        tick(1);
        hwintExpect("edgeHwint", 6'h04);
        readExpect("edgeId", IRQ_ID, 32'h8000_0002);
        applyStimulus(6'h00);
        busWrite(IRQ_PEND, 32'h04);
        readExpect("ackPend", IRQ_PEND, 32'h0);
        readExpect("ackId", IRQ_ID, 32'h0);
        hwintExpect("ackHwintLag", 6'h04);
        tick(1);
        hwintExpect("ackHwint", 6'h00);

        // Level mode
        busWrite(IRQ_MODE, 32'h00);
        busWrite(IRQ_MASK, 32'h20);
        applyStimulus(6'h20);
        tick(4);
        readExpect("levelPend", IRQ_PEND, 32'h20);
        hwintExpect("levelHwint", 6'h20);
        busWrite(IRQ_PEND, 32'h20);
        readExpect("levelIgnoresW1c", IRQ_PEND, 32'h20);
        applyStimulus(6'h00);
        tick(3);
        readExpect("levelDropPend", IRQ_PEND, 32'h0);
        hwintExpect("levelDropHwintLag", 6'h20);
        tick(1);
        hwintExpect("levelDropHwint", 6'h00);

        // Mask gating
        busWrite(IRQ_MODE, 32'h01);
        busWrite(IRQ_MASK, 32'h00);
        applyStimulus(6'h01);
        tick(4);
        readExpect("maskedPend", IRQ_PEND, 32'h01);
        hwintExpect("maskedHwint", 6'h00);
        busWrite(IRQ_MASK, 32'h01);
        hwintExpect("unmaskLag", 6'h00);
        tick(1);
        hwintExpect("unmaskHwint", 6'h01);
        applyStimulus(6'h00);
        busWrite(IRQ_PEND, 32'h01);
        readExpect("maskAckPend", IRQ_PEND, 32'h0);

        // Set/clear collision on source 3
        busWrite(IRQ_MODE, 32'h3F);
        applyStimulus(6'h08);
        tick(4);
        readExpect("collPrePend", IRQ_PEND, 32'h08);
        applyStimulus(6'h00);
        tick(4);
        applyStimulus(6'h08);
        tick(2);
        busWrite(IRQ_PEND, 32'h08);
        readExpect("collSetWins", IRQ_PEND, 32'h08);
        busWrite(IRQ_PEND, 32'h08);
        readExpect("collLaterAck", IRQ_PEND, 32'h0);
        applyStimulus(6'h00);

        // Priority and ID
        busWrite(IRQ_MASK, 32'hFFFF_FFFF);
        readExpect("maskUpperIgnored", IRQ_MASK, 32'h3F);
        applyStimulus(6'h12);
        tick(4);
        applyStimulus(6'h00);
        readExpect("prioPend", IRQ_PEND, 32'h12);
        readExpect("prioId1", IRQ_ID, 32'h8000_0001);
        busWrite(IRQ_ID, 32'hFFFF_FFFF);
        readExpect("idWriteIgnored", IRQ_ID, 32'h8000_0001);
        busWrite(IRQ_PEND, 32'h02);
        readExpect("prioId4", IRQ_ID, 32'h8000_0004);
        busWrite(IRQ_PEND, 32'h10);
        readExpect("prioIdNone", IRQ_ID, 32'h0);
        pushExpect("rdataNoSel", 32'h0);
        sel  = 1'b0;
        addr = IRQ_MASK;
        #1;
        popCompare(rdata);

        // Asynchronous reset while everything is pending
        applyStimulus(6'h3F);
        tick(4);
        applyStimulus(6'h00);
        readExpect("preRstPend", IRQ_PEND, 32'h3F);
        hwintExpect("preRstHwint", 6'h3F);
        #1 reset = 1'b0;
        #1;
        readExpect("asyncRstPend", IRQ_PEND, 32'h0);
        readExpect("asyncRstMask", IRQ_MASK, 32'h0);
        readExpect("asyncRstMode", IRQ_MODE, 32'h0);
        hwintExpect("asyncRstHwint", 6'h00);
        readExpect("asyncRstId", IRQ_ID, 32'h0);
        #4 reset = 1'b1;
        tick(2);
        readExpect("postRstPend", IRQ_PEND, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
